exu_mdu_ysyx23060136: RTL and testbench

Parametrised iterative multiply/divide unit for the EXU stage of the pipelined RV32 core, executing all eight RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the single-cycle ALU and uses valid/ready handshakes on both sides so the EXU can stall its upstream stages while an operation is in flight. A branch flush from the EXU kills any in-flight operation.

---
 rtl/exu_mdu_ysyx23060136.sv | 251 +++++++++++++++++++++++++
 tb/tb_exu_mdu_ysyx23060136.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_mdu_ysyx23060136.sv
// Iterative RV32M/RV64M multiply/divide unit for the EXU stage.
// Multiplies run through a MUL_LATENCY-deep product pipe; divides use radix-2 restoring steps.
module exu_mdu_ysyx23060136 #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            MDU_i_valid,
    output logic            MDU_o_ready,
    input  logic [2:0]      MDU_i_op,
    input  logic [XLEN-1:0] MDU_i_rs1_data,
    input  logic [XLEN-1:0] MDU_i_rs2_data,
    input  logic [4:0]      MDU_i_rd,
    input  logic            MDU_i_flush,
    output logic            MDU_o_valid,
    input  logic            MDU_i_ready,
    output logic [XLEN-1:0] MDU_o_result,
    output logic [4:0]      MDU_o_rd,
    output logic            MDU_o_busy
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_MUL  = CW'(MUL_LATENCY - 1);
    localparam logic [CW-1:0]   CNT_DIV  = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [CW-1:0]     cnt_q;
    logic              fix_q;
    logic              neg_quo_q;
    logic              neg_rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   dvs_q;
    logic              valid_q;
    logic [XLEN-1:0]   result_q;
    logic [2*XLEN-1:0] pipe_q [MUL_LATENCY];

    logic              accept_s;
    logic              mul_sa_s;
    logic              mul_sb_s;
    logic [2*XLEN-1:0] mul_a_s;
    logic [2*XLEN-1:0] mul_b_s;
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] mul_tap_s;
    logic [XLEN-1:0]   mul_res_s;
    logic              div_signed_s;
    logic              rs1_neg_s;
    logic              rs2_neg_s;
    logic [XLEN-1:0]   abs1_s;
    logic [XLEN-1:0]   abs2_s;
    logic              div_zero_s;
    logic              div_ovf_s;
    logic [XLEN:0]     shift_s;
    logic              ge_s;
    logic [XLEN-1:0]   sub_s;
    logic [XLEN-1:0]   quo_fix_s;
    logic [XLEN-1:0]   rem_fix_s;

    assign accept_s = (state_q == S_IDLE) & MDU_i_valid & ~MDU_i_flush;

    // The low 2*XLEN bits of the sign/zero-extended product are all any multiply op needs.
    assign mul_sa_s  = (MDU_i_op == 3'd1) | (MDU_i_op == 3'd2);
    assign mul_sb_s  = (MDU_i_op == 3'd1);
    assign mul_a_s   = {{XLEN{mul_sa_s & MDU_i_rs1_data[XLEN-1]}}, MDU_i_rs1_data};
    assign mul_b_s   = {{XLEN{mul_sb_s & MDU_i_rs2_data[XLEN-1]}}, MDU_i_rs2_data};
    assign prod_s    = mul_a_s * mul_b_s;
    assign mul_tap_s = pipe_q[MUL_LATENCY-1];
    assign mul_res_s = (op_q == 3'd0) ? mul_tap_s[XLEN-1:0] : mul_tap_s[2*XLEN-1:XLEN];

    assign div_signed_s = MDU_i_op[2] & ~MDU_i_op[0];
    assign rs1_neg_s    = div_signed_s & MDU_i_rs1_data[XLEN-1];
    assign rs2_neg_s    = div_signed_s & MDU_i_rs2_data[XLEN-1];
    assign abs1_s       = rs1_neg_s ? (ZERO - MDU_i_rs1_data) : MDU_i_rs1_data;
    assign abs2_s       = rs2_neg_s ? (ZERO - MDU_i_rs2_data) : MDU_i_rs2_data;
    assign div_zero_s   = (MDU_i_rs2_data == ZERO);
    assign div_ovf_s    = div_signed_s & (MDU_i_rs1_data == MOST_NEG) & (MDU_i_rs2_data == ONES);

    // Dividend bits shift out of quo_q into the partial remainder; quotient bits shift in.
    assign shift_s   = {rem_q, quo_q[XLEN-1]};
    assign ge_s      = (shift_s >= {1'b0, dvs_q});
    assign sub_s     = shift_s[XLEN-1:0] - dvs_q;
    assign quo_fix_s = neg_quo_q ? (ZERO - quo_q) : quo_q;
    assign rem_fix_s = neg_rem_q ? (ZERO - rem_q) : rem_q;

    assign MDU_o_ready  = (state_q == S_IDLE);
    assign MDU_o_busy   = (state_q != S_IDLE);
    assign MDU_o_valid  = valid_q;
    assign MDU_o_result = result_q;
    assign MDU_o_rd     = rd_q;

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        if (MDU_i_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (MDU_i_valid) begin
                        state_d = MDU_i_op[2] ? S_DIV : S_MUL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_MUL: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_MUL;
                    end
                end
                S_DIV: begin
                    if (fix_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIV;
                    end
                end
                S_DONE: begin
                    if (MDU_i_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, division iterations and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= 3'd0;
            rd_q      <= 5'd0;
            cnt_q     <= CNT_ZERO;
            fix_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= ZERO;
            rem_q     <= ZERO;
            dvs_q     <= ZERO;
            valid_q   <= 1'b0;
            result_q  <= ZERO;
        end else if (MDU_i_flush) begin
            valid_q <= 1'b0;
            fix_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (MDU_i_valid) begin
                        op_q  <= MDU_i_op;
                        rd_q  <= MDU_i_rd;
                        dvs_q <= abs2_s;
                        if (!MDU_i_op[2]) begin
                            cnt_q     <= CNT_MUL;
                            fix_q     <= 1'b0;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                        end else if (div_zero_s | div_ovf_s) begin
                            // Special cases skip iteration and go straight to the fixup step.
                            cnt_q     <= CNT_ZERO;
                            fix_q     <= 1'b1;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                            quo_q     <= div_zero_s ? ONES : MDU_i_rs1_data;
                            rem_q     <= div_zero_s ? MDU_i_rs1_data : ZERO;
                        end else begin
                            cnt_q     <= CNT_DIV;
                            fix_q     <= 1'b0;
                            neg_quo_q <= rs1_neg_s ^ rs2_neg_s;
                            neg_rem_q <= rs1_neg_s;
                            quo_q     <= abs1_s;
                            rem_q     <= ZERO;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == CNT_ZERO) begin
                        result_q <= mul_res_s;
                        valid_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_DIV: begin
                    if (fix_q) begin
                        result_q <= op_q[1] ? rem_fix_s : quo_fix_s;
                        valid_q  <= 1'b1;
                        fix_q    <= 1'b0;
                    end else begin
                        rem_q <= ge_s ? sub_s : shift_s[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], ge_s};
                        if (cnt_q == CNT_ZERO) begin
                            fix_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                end
                S_DONE: begin
                    if (MDU_i_ready) begin
                        valid_q <= 1'b0;
                    end
                end
                default: valid_q <= 1'b0;
            endcase
        end
    end

    // Product pipe: stage 0 captures on accept, so the last stage is ready after MUL_LATENCY-1 edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LATENCY; i++) begin
                pipe_q[i] <= {(2*XLEN){1'b0}};
            end
        end else begin
            if (accept_s) begin
                pipe_q[0] <= prod_s;
            end
            for (int i = 1; i < MUL_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_exu_mdu_ysyx23060136.sv
// Directed bench for exu_mdu_ysyx23060136: a 32-bit/latency-2 instance and a 64-bit/latency-1 instance
// checked against an arithmetic reference model through per-instance expectation queues.
module tb_exu_mdu_ysyx23060136;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_ivalid, a_oready, a_flush, a_ovalid, a_iready, a_busy;
    logic [2:0]  a_op;
    logic [31:0] a_rs1, a_rs2, a_res;
    logic [4:0]  a_rd, a_ord;

    logic        b_ivalid, b_oready, b_flush, b_ovalid, b_iready, b_busy;
    logic [2:0]  b_op;
    logic [63:0] b_rs1, b_rs2, b_res;
    logic [4:0]  b_rd, b_ord;

    exu_mdu_ysyx23060136 #(.XLEN(32), .MUL_LATENCY(2)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .MDU_i_valid(a_ivalid), .MDU_o_ready(a_oready), .MDU_i_op(a_op),
        .MDU_i_rs1_data(a_rs1), .MDU_i_rs2_data(a_rs2), .MDU_i_rd(a_rd),
        .MDU_i_flush(a_flush), .MDU_o_valid(a_ovalid), .MDU_i_ready(a_iready),
        .MDU_o_result(a_res), .MDU_o_rd(a_ord), .MDU_o_busy(a_busy)
    );

    exu_mdu_ysyx23060136 #(.XLEN(64), .MUL_LATENCY(1)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .MDU_i_valid(b_ivalid), .MDU_o_ready(b_oready), .MDU_i_op(b_op),
        .MDU_i_rs1_data(b_rs1), .MDU_i_rs2_data(b_rs2), .MDU_i_rd(b_rd),
        .MDU_i_flush(b_flush), .MDU_o_valid(b_ovalid), .MDU_i_ready(b_iready),
        .MDU_o_result(b_res), .MDU_o_rd(b_ord), .MDU_o_busy(b_busy)
    );

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   n_tests;
    int   n_fail;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on wide integers.
    function automatic logic [63:0] model(input int xlen, input logic [2:0] op,
                                          input logic [63:0] x_in, input logic [63:0] y_in);
        logic [63:0]         mask, most_neg, x, y;
        logic signed [129:0] ex, ey, p, span, q, r;
        bit                  sx, sy;
        mask     = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        most_neg = (xlen == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
        x  = x_in & mask;
        y  = y_in & mask;
        sx = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        sy = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        span = 130'sd1 <<< xlen;
        ex = $signed({66'd0, x});
        ey = $signed({66'd0, y});
        if (sx && ((x & most_neg) != 64'd0)) ex = ex - span;
        if (sy && ((y & most_neg) != 64'd0)) ey = ey - span;
        if (op < 3'd4) begin
            p = ex * ey;
            if (op == 3'd0) return p[63:0] & mask;
            p = p >>> xlen;
            return p[63:0] & mask;
        end
        if (y == 64'd0) return op[1] ? x : mask;
        if (sx && (x == most_neg) && (y == mask)) return op[1] ? 64'd0 : x;
        q = ex / ey;
        r = ex % ey;
        return (op[1] ? r[63:0] : q[63:0]) & mask;
    endfunction

    function automatic logic ovalid(input bit w);
        return w ? b_ovalid : a_ovalid;
    endfunction

    function automatic logic oready(input bit w);
        return w ? b_oready : a_oready;
    endfunction

    // Compare process: every cycle a result is presented it must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && a_ovalid) begin
            if (q32.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL m32_unexpected_valid actual=1 required=0 rd=%0d res=%h", a_ord, a_res);
            end else begin
                chk("m32_result", {32'd0, a_res}, q32[0].res);
                chk("m32_rd", {59'd0, a_ord}, {59'd0, q32[0].rd});
                if (a_iready) q32.delete(0);
            end
        end
        if (rst_n && b_ovalid) begin
            if (q64.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL m64_unexpected_valid actual=1 required=0 rd=%0d res=%h", b_ord, b_res);
            end else begin
                chk("m64_result", b_res, q64[0].res);
                chk("m64_rd", {59'd0, b_ord}, {59'd0, q64[0].rd});
                if (b_iready) q64.delete(0);
            end
        end
    end

    task automatic issue(input bit w, input logic [2:0] op, input logic [63:0] x, input logic [63:0] y,
                         input logic [4:0] rd, input bit track, input logic [63:0] lit, input string nm);
        int   n;
        exp_t e;
        n = 0;
        while (!oready(w) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (track) begin
            e.res = model(w ? 64 : 32, op, x, y);
            e.rd  = rd;
            chk({nm, "_model"}, e.res, lit);
            if (w) q64.push_back(e);
            else   q32.push_back(e);
        end
        if (w) begin
            b_ivalid = 1'b1; b_op = op; b_rs1 = x; b_rs2 = y; b_rd = rd;
        end else begin
            a_ivalid = 1'b1; a_op = op; a_rs1 = x[31:0]; a_rs2 = y[31:0]; a_rd = rd;
        end
        @(posedge clk); #1;
        a_ivalid = 1'b0; b_ivalid = 1'b0;
        a_rs1 = $urandom; a_rs2 = $urandom; a_op = 3'($urandom_range(0, 7));
        b_rs1 = {$urandom, $urandom}; b_rs2 = {$urandom, $urandom}; b_op = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_valid(input bit w, input int lat, input string nm);
        int n;
        n = 0;
        while (!ovalid(w) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'(lat));
    endtask

    task automatic run_op(input bit w, input logic [2:0] op, input logic [63:0] x, input logic [63:0] y,
                          input logic [4:0] rd, input logic [63:0] lit, input int lat, input string nm);
        issue(w, op, x, y, rd, 1'b1, lit, nm);
        wait_valid(w, lat, nm);
        if (w ? b_iready : a_iready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic expect_quiet(input bit w, input int cycles, input string nm);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (ovalid(w)) seen++;
        end
        chk(nm, 64'(seen), 64'd0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        a_ivalid = 1'b0; a_flush = 1'b0; a_iready = 1'b1; a_op = 3'd0; a_rs1 = 32'd0; a_rs2 = 32'd0; a_rd = 5'd0;
        b_ivalid = 1'b0; b_flush = 1'b0; b_iready = 1'b1; b_op = 3'd0; b_rs1 = 64'd0; b_rs2 = 64'd0; b_rd = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, a_ovalid}, 64'd0);
        chk("rst_result", {32'd0, a_res}, 64'd0);
        chk("rst_rd", {59'd0, a_ord}, 64'd0);
        chk("rst_busy", {63'd0, a_busy}, 64'd0);
        chk("rst_ready", {63'd0, a_oready}, 64'd1);
        chk("rst64_result", b_res, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", {63'd0, a_oready}, 64'd1);

        // 32-bit multiplies
        run_op(1'b0, 3'd1, 64'h8000_0000, 64'h8000_0000, 5'd1, 64'h4000_0000, 2, "mulh_minneg");
        run_op(1'b0, 3'd0, 64'h8000_0000, 64'h8000_0000, 5'd2, 64'h0000_0000, 2, "mul_minneg");
        run_op(1'b0, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd3, 64'hFFFF_FFFF, 2, "mulhsu_ones");
        run_op(1'b0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd4, 64'hFFFF_FFFE, 2, "mulhu_ones");
        run_op(1'b0, 3'd0, 64'h1234_5678, 64'h0000_0009, 5'd5, 64'hA3D7_0A38, 2, "mul_x9");
        run_op(1'b0, 3'd1, 64'hFFFF_FFFD, 64'h0000_0005, 5'd6, 64'hFFFF_FFFF, 2, "mulh_neg");

        // 32-bit divides
        run_op(1'b0, 3'd4, 64'hFFFF_FFF9, 64'h0000_0002, 5'd7, 64'hFFFF_FFFD, 33, "div_m7_2");
        run_op(1'b0, 3'd6, 64'hFFFF_FFF9, 64'h0000_0002, 5'd8, 64'hFFFF_FFFF, 33, "rem_m7_2");
        run_op(1'b0, 3'd5, 64'd100, 64'd7, 5'd9, 64'd14, 33, "divu_100_7");
        run_op(1'b0, 3'd7, 64'd100, 64'd7, 5'd10, 64'd2, 33, "remu_100_7");
        run_op(1'b0, 3'd4, 64'h0000_0007, 64'hFFFF_FFFE, 5'd11, 64'hFFFF_FFFD, 33, "div_7_m2");
        run_op(1'b0, 3'd6, 64'h0000_0007, 64'hFFFF_FFFE, 5'd12, 64'h0000_0001, 33, "rem_7_m2");

        // Special cases
        run_op(1'b0, 3'd5, 64'h1234_5678, 64'd0, 5'd13, 64'hFFFF_FFFF, 1, "divu_by0");
        run_op(1'b0, 3'd6, 64'h0000_1234, 64'd0, 5'd14, 64'h0000_1234, 1, "rem_by0");
        run_op(1'b0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 5'd15, 64'h8000_0000, 1, "div_ovf");
        run_op(1'b0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 5'd16, 64'h0000_0000, 1, "rem_ovf");

        // Backpressure in DONE
        a_iready = 1'b0;
        issue(1'b0, 3'd5, 64'd100, 64'd7, 5'd17, 1'b1, 64'd14, "bp_divu");
        wait_valid(1'b0, 33, "bp_divu");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {63'd0, a_ovalid}, 64'd1);
            chk("bp_result", {32'd0, a_res}, 64'd14);
            chk("bp_rd", {59'd0, a_ord}, 64'd17);
            chk("bp_ready", {63'd0, a_oready}, 64'd0);
        end
        a_iready = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready_after", {63'd0, a_oready}, 64'd1);
        chk("bp_valid_after", {63'd0, a_ovalid}, 64'd0);

        // Flush at iteration 10, then a clean request
        issue(1'b0, 3'd4, 64'h0000_1000, 64'd3, 5'd18, 1'b0, 64'd0, "fl_div");
        repeat (10) @(posedge clk);
        #1; a_flush = 1'b1;
        @(posedge clk); #1; a_flush = 1'b0;
        chk("fl_busy", {63'd0, a_busy}, 64'd0);
        chk("fl_ready", {63'd0, a_oready}, 64'd1);
        chk("fl_valid", {63'd0, a_ovalid}, 64'd0);
        expect_quiet(1'b0, 40, "fl_no_result");
        run_op(1'b0, 3'd4, 64'h0000_1000, 64'd3, 5'd19, 64'h0000_0555, 33, "after_flush");

        // Flush coincident with a request
        a_ivalid = 1'b1; a_flush = 1'b1; a_op = 3'd5; a_rs1 = 32'd50; a_rs2 = 32'd5; a_rd = 5'd20;
        @(posedge clk); #1;
        a_ivalid = 1'b0; a_flush = 1'b0;
        chk("flv_busy", {63'd0, a_busy}, 64'd0);
        expect_quiet(1'b0, 40, "flv_no_result");

        // 64-bit instance
        run_op(1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd21, 64'hFFFF_FFFF_FFFF_FFFE, 1, "mulhu64");
        run_op(1'b1, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd22, 64'h0, 1, "mulh64_m1");
        run_op(1'b1, 3'd5, 64'h8000_0000_0000_0000, 64'd3, 5'd23, 64'h2AAA_AAAA_AAAA_AAAA, 65, "divu64");
        run_op(1'b1, 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd24, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div64_m7");

        // Reset in the middle of a 64-bit divide
        issue(1'b1, 3'd5, 64'h8000_0000_0000_0000, 64'd3, 5'd25, 1'b0, 64'd0, "rst_div64");
        repeat (20) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, b_ovalid}, 64'd0);
        chk("mid_rst_busy", {63'd0, b_busy}, 64'd0);
        chk("mid_rst_ready", {63'd0, b_oready}, 64'd1);
        chk("mid_rst_result", b_res, 64'd0);
        chk("mid_rst_rd", {59'd0, b_ord}, 64'd0);
        #1; rst_n = 1'b1;
        expect_quiet(1'b1, 80, "mid_rst_no_result");

        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q64_drained", 64'(q64.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
